// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the main FSM and the multi-cycle datapath.
interface multicycle_control_if #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 16
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic [CNT_W-1:0]   instr_count;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multi-cycle MIPS datapath, sequencing
// fetch/decode/execute/memory/writeback and stalling on mem_ready.
module multicycle_control #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH     = 'd0,
        DECODE    = 'd1,
        MEM_ADDR  = 'd2,
        MEM_READ  = 'd3,
        MEM_WB    = 'd4,
        MEM_WRITE = 'd5,
        EXEC_R    = 'd6,
        R_WB      = 'd7,
        BRANCH    = 'd8,
        JUMP      = 'd9,
        EXEC_I    = 'd10,
        I_WB      = 'd11
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             legal;
    logic             retire;

    assign legal  = bus.opcode inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    assign retire = (state inside {MEM_WB, R_WB, BRANCH, JUMP, I_WB}) ||
                    (state == MEM_WRITE && bus.mem_ready);

    assign bus.instr_count = cnt;
    assign bus.state_dbg   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(retire);
            case (state)
                FETCH:     state <= bus.mem_ready ? DECODE : FETCH;
                DECODE:    state <= (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
                                    bus.opcode == OP_R    ? EXEC_R :
                                    bus.opcode == OP_BEQ  ? BRANCH :
                                    bus.opcode == OP_J    ? JUMP   :
                                    bus.opcode == OP_ADDI ? EXEC_I : FETCH;
                MEM_ADDR:  state <= bus.opcode == OP_SW ? MEM_WRITE : MEM_READ;
                MEM_READ:  state <= bus.mem_ready ? MEM_WB : MEM_READ;
                MEM_WRITE: state <= bus.mem_ready ? FETCH : MEM_WRITE;
                EXEC_R:    state <= R_WB;
                EXEC_I:    state <= I_WB;
                default:   state <= FETCH;
            endcase
        end
    end

    // Decoded straight from state so outputs track an asynchronous reset without an edge.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_b  = 2'b11;
                    bus.illegal_op = !legal;
                end
                MEM_ADDR, EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                end
                JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end
                I_WB: bus.reg_write = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vector table, hand-written stall/reset sequences
// and randomized instruction streams checked against an instruction-level model.
module tb_multicycle_control;
    localparam int CNT_W = 4;

    // Packed as {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    localparam logic [16:0] V_F0   = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] V_F1   = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] V_DEC  = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] V_DECI = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] V_MA   = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] V_MR   = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] V_MWB  = 17'b0000001010_00_00_00_0;
    localparam logic [16:0] V_MW   = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] V_ER   = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] V_RWB  = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] V_BR   = 17'b0100000001_00_01_01_0;
    localparam logic [16:0] V_J    = 17'b1000000000_00_00_10_0;
    localparam logic [16:0] V_EI   = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] V_IWB  = 17'b0000000010_00_00_00_0;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] v;
        logic [3:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    multicycle_control_if #(.STATE_W(4), .CNT_W(CNT_W)) bus ();
    multicycle_control #(.STATE_W(4), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] es,
                        input logic [16:0] ev, input logic [3:0] ec, input string tag);
        bus.opcode    = op;
        bus.mem_ready = mr;
        @(negedge clk);
        chk({tag, " state"}, 32'(bus.state_dbg), 32'(es));
        chk({tag, " outs"}, 32'(outs), 32'(ev));
        chk({tag, " cnt"}, 32'(bus.instr_count), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    logic [16:0] exp_tbl [12];
    int          path[$];
    logic [5:0]  op, drv;
    logic [16:0] ev;
    logic [3:0]  exp_cnt;
    logic        mr, illegal;
    int          s, stall, mw_cycles, k;

    initial begin
        exp_tbl = '{V_F0, V_DEC, V_MA, V_MR, V_MWB, V_MW, V_ER, V_RWB, V_BR, V_J, V_EI, V_IWB};

        // lw, R-type, beq, j, illegal, then a stalled fetch; all with mem_ready high otherwise
        tbl.push_back('{6'h23, 1'b1, 4'd0, V_F1,   4'd0});
        tbl.push_back('{6'h23, 1'b1, 4'd1, V_DEC,  4'd0});
        tbl.push_back('{6'h23, 1'b1, 4'd2, V_MA,   4'd0});
        tbl.push_back('{6'h23, 1'b1, 4'd3, V_MR,   4'd0});
        tbl.push_back('{6'h23, 1'b1, 4'd4, V_MWB,  4'd0});
        tbl.push_back('{6'h00, 1'b1, 4'd0, V_F1,   4'd1});
        tbl.push_back('{6'h00, 1'b1, 4'd1, V_DEC,  4'd1});
        tbl.push_back('{6'h00, 1'b1, 4'd6, V_ER,   4'd1});
        tbl.push_back('{6'h00, 1'b1, 4'd7, V_RWB,  4'd1});
        tbl.push_back('{6'h04, 1'b1, 4'd0, V_F1,   4'd2});
        tbl.push_back('{6'h04, 1'b1, 4'd1, V_DEC,  4'd2});
        tbl.push_back('{6'h04, 1'b1, 4'd8, V_BR,   4'd2});
        tbl.push_back('{6'h02, 1'b1, 4'd0, V_F1,   4'd3});
        tbl.push_back('{6'h02, 1'b1, 4'd1, V_DEC,  4'd3});
        tbl.push_back('{6'h02, 1'b1, 4'd9, V_J,    4'd3});
        tbl.push_back('{6'h3f, 1'b1, 4'd0, V_F1,   4'd4});
        tbl.push_back('{6'h3f, 1'b1, 4'd1, V_DECI, 4'd4});
        tbl.push_back('{6'h3f, 1'b0, 4'd0, V_F0,   4'd4});

        bus.opcode    = 6'b100011;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", 32'(outs), 32'd0);
        chk("reset state", 32'(bus.state_dbg), 32'd0);
        chk("reset cnt", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].v, tbl[i].cnt, $sformatf("vec%0d", i));

        // sw: 3 stall cycles in FETCH, 2 in MEM_WRITE, 9 cycles total
        mw_cycles = 0;
        repeat (3) step(6'h2b, 1'b0, 4'd0, V_F0, 4'd4, "sw fetch stall");
        step(6'h2b, 1'b1, 4'd0, V_F1, 4'd4, "sw fetch");
        step(6'h2b, 1'b1, 4'd1, V_DEC, 4'd4, "sw decode");
        step(6'h2b, 1'b1, 4'd2, V_MA, 4'd4, "sw addr");
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            @(negedge clk);
            mw_cycles += int'(bus.mem_write);
            chk("sw write state", 32'(bus.state_dbg), 32'd5);
            @(posedge clk);
            #1;
        end
        chk("sw mem_write cycles", 32'(mw_cycles), 32'd3);
        step(6'h2b, 1'b0, 4'd0, V_F0, 4'd5, "sw retired");

        // asynchronous reset while stalled in MEM_READ
        step(6'h23, 1'b1, 4'd0, V_F1, 4'd5, "lw2 fetch");
        step(6'h23, 1'b1, 4'd1, V_DEC, 4'd5, "lw2 decode");
        step(6'h23, 1'b1, 4'd2, V_MA, 4'd5, "lw2 addr");
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("lw2 memread outs", 32'(outs), 32'(V_MR));
        #2 rst_n = 1'b0;
        #1;
        chk("midreset outs", 32'(outs), 32'd0);
        chk("midreset state", 32'(bus.state_dbg), 32'd0);
        chk("midreset cnt", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // random instruction stream; model works per instruction class, counter wraps at 16
        exp_cnt = '0;
        stall = 0;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 6);
            path.delete();
            illegal = 1'b0;
            case (k)
                0: begin op = 6'h23; path = '{0, 1, 2, 3, 4}; end
                1: begin op = 6'h2b; path = '{0, 1, 2, 5}; end
                2: begin op = 6'h00; path = '{0, 1, 6, 7}; end
                3: begin op = 6'h04; path = '{0, 1, 8}; end
                4: begin op = 6'h02; path = '{0, 1, 9}; end
                5: begin op = 6'h08; path = '{0, 1, 10, 11}; end
                default: begin
                    illegal = 1'b1;
                    path = '{0, 1};
                    do op = 6'($urandom);
                    while (op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08});
                end
            endcase
            for (int i = 0; i < path.size(); ) begin
                s   = path[i];
                mr  = (stall >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
                drv = (s == 1 || s == 2) ? op : 6'($urandom);
                ev  = exp_tbl[s];
                if (s == 0 && mr) ev = V_F1;
                if (s == 1 && illegal) ev = V_DECI;
                step(drv, mr, 4'(s), ev, exp_cnt, $sformatf("rand%0d", n));
                if ((s == 0 || s == 3 || s == 5) && !mr) stall++;
                else begin
                    stall = 0;
                    i++;
                end
            end
            if (!illegal) exp_cnt = exp_cnt + 4'd1;
        end
        step(6'h00, 1'b0, 4'd0, V_F0, exp_cnt, "rand final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
